uart_rx: RTL

- UART receiver; the counterpart of the team's UART transmitter. Frame format is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), with idle line high.
- Oversamples the serial line at CLKS_PER_BIT clocks per bit and samples each bit at mid-bit.
- Delivers each byte with a one-cycle valid strobe.
- Flags bad stop bits.
- Sits between the pad/loopback line and the byte-level consumer.

---
 rtl/uart_rx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, oversampled at CLKS_PER_BIT clocks per bit, sampled mid-bit.
// Delivers each good byte with a one-cycle valid strobe and flags bad stop bits.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       in,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    logic             s1_q, in_s_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bits_q, bits_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= 1'b1;
            in_s_q <= 1'b1;
        end else begin
            s1_q   <= in;
            in_s_q <= s1_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                bits_d = '0;
                if (enable && !in_s_q) begin
                    state_d = START;
                end
            end

            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_HALF_M1) begin
                    cnt_d   = '0;
                    bits_d  = '0;
                    // A line back high at mid start bit was only a glitch.
                    state_d = in_s_q ? IDLE : DATA;
                end
            end

            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d           = '0;
                    shift_d[bits_q] = in_s_q;
                    if (bits_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bits_d = bits_q + 3'd1;
                    end
                end
            end

            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (in_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule
